// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types and constants for the washing-machine balance keeper
package wm_pkg;

  // Saturation ceiling of the customer balance, BCD.
  localparam logic [11:0] BAL_MAX = 12'h999;

  // One BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Coin values as 3-digit BCD operands.
  localparam logic [11:0] COIN_VAL_1  = 12'h001;
  localparam logic [11:0] COIN_VAL_5  = 12'h005;
  localparam logic [11:0] COIN_VAL_10 = 12'h010;

  // Charge handling FSM.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMP      = 2'd1,
    RESP     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/balance_ctrl_if.sv
// rtl/balance_ctrl_if.sv - billing-side bus of the balance keeper
// master: billing (drives charge_req/price, reads balance and pulses)
// slave : balance_ctrl
//   charge_req   level request, price must stay stable while high
//   price        BCD price, 3 nibbles
//   bal          current balance, BCD, registered
//   charge_ack   1-cycle pulse, deduction done
//   charge_nak   1-cycle pulse, insufficient funds or invalid price
//   refund_pulse 1-cycle pulse, balance cleared
interface balance_ctrl_if;
  logic        charge_req;
  logic [11:0] price;
  logic [11:0] bal;
  logic        charge_ack;
  logic        charge_nak;
  logic        refund_pulse;

  modport master (
    output charge_req, price,
    input  bal, charge_ack, charge_nak, refund_pulse
  );

  modport slave (
    input  charge_req, price,
    output bal, charge_ack, charge_nak, refund_pulse
  );
endinterface

// File: rtl/debounce.sv
// rtl/debounce.sv - button debouncer with rising-edge pulse
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   din   raw button level
//   pulse 1-cycle pulse on a debounced rising edge
// Latency from a stable raw edge to pulse is DB_CYCLES+2 cycles:
// two synchronizer flops, then DB_CYCLES cycles of disagreement with
// the accepted level before the new level is taken.
module debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        // Any bounce back to the accepted level restarts the count.
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;   // only the rising edge produces a pulse
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/balance_ctrl.sv
// rtl/balance_ctrl.sv - customer balance keeper: coins, charge, refund
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   coin   raw coin buttons: bit0 +1, bit1 +5, bit2 +10
//   refund raw refund button
//   bus    billing bus (charge_req, price, bal, charge_ack, charge_nak, refund_pulse)
module balance_ctrl #(
  parameter int          DB_CYCLES = 2_000_000,
  parameter logic [11:0] BAL_MAX   = wm_pkg::BAL_MAX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     coin,
  input  logic           refund,
  balance_ctrl_if.slave  bus
);

  import wm_pkg::*;

  // Per-digit BCD add; bit 12 is the carry out of the hundreds digit.
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        c;
    logic [11:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, bcd_digit_t'(a[i*4 +: 4])} + {1'b0, bcd_digit_t'(b[i*4 +: 4])} + {4'd0, c};
      if (s > 5'd9) s = s + 5'd6;
      r[i*4 +: 4] = s[3:0];
      c           = s[4];
    end
    return {c, r};
  endfunction

  // Per-digit BCD subtract with borrow; caller guarantees a >= b.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  d;
    logic        br;
    logic [11:0] r;
    br = 1'b0;
    r  = '0;
    for (int i = 0; i < 3; i++) begin
      d  = {1'b0, bcd_digit_t'(a[i*4 +: 4])} - {1'b0, bcd_digit_t'(b[i*4 +: 4])} - {4'd0, br};
      br = d[4];
      if (br) d = d + 5'd10;
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  // Debounced button pulses.
  logic [2:0] coin_p;
  logic       refund_p;

  for (genvar g = 0; g < 3; g++) begin : g_coin_db
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (coin[g]),
      .pulse (coin_p[g])
    );
  end

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_refund (
    .clk   (clk),
    .rst   (rst),
    .din   (refund),
    .pulse (refund_p)
  );

  state_t      state, state_nxt;
  logic [11:0] bal_q, bal_nxt;
  logic [11:0] price_q, price_nxt;
  logic [11:0] diff_q, diff_nxt;
  logic        ok_q, ok_nxt;
  logic [2:0]  pend_q, pend_nxt;
  logic        refund_q, refund_nxt;
  logic        ack_q, ack_nxt;
  logic        nak_q, nak_nxt;
  logic        rp_q, rp_nxt;

  // This cycle's pulses count as pending at once, so a coin lands one
  // cycle after its pulse and nothing arriving during a charge is lost.
  logic [2:0]  pend_eff;
  logic        refund_eff;
  logic [2:0]  coin_sel;
  logic [11:0] coin_val;
  logic [12:0] coin_sum;
  logic [11:0] coin_bal;

  assign pend_eff   = pend_q | coin_p;
  assign refund_eff = refund_q | refund_p;

  // Highest-value pending coin wins.
  always_comb begin
    coin_sel = 3'b000;
    coin_val = 12'h000;
    if (pend_eff[2]) begin
      coin_sel = 3'b100;
      coin_val = COIN_VAL_10;
    end else if (pend_eff[1]) begin
      coin_sel = 3'b010;
      coin_val = COIN_VAL_5;
    end else if (pend_eff[0]) begin
      coin_sel = 3'b001;
      coin_val = COIN_VAL_1;
    end
  end

  // Valid BCD values compare correctly as plain binary.
  assign coin_sum = bcd_add(bal_q, coin_val);
  assign coin_bal = (coin_sum[12] || (coin_sum[11:0] > BAL_MAX)) ? BAL_MAX : coin_sum[11:0];

  always_comb begin
    state_nxt  = state;
    bal_nxt    = bal_q;
    price_nxt  = price_q;
    diff_nxt   = diff_q;
    ok_nxt     = ok_q;
    pend_nxt   = pend_eff;
    refund_nxt = refund_eff;
    ack_nxt    = 1'b0;
    nak_nxt    = 1'b0;
    rp_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.charge_req) begin
          price_nxt = bus.price;
          state_nxt = CMP;
        end else if (refund_eff) begin
          bal_nxt    = 12'h000;
          rp_nxt     = 1'b1;
          refund_nxt = 1'b0;
        end else if (|pend_eff) begin
          bal_nxt  = coin_bal;
          pend_nxt = pend_eff & ~coin_sel;
        end
      end
      CMP: begin
        ok_nxt    = bcd_valid(price_q) && (bal_q >= price_q);
        diff_nxt  = bcd_sub(bal_q, price_q);
        state_nxt = RESP;
      end
      RESP: begin
        if (ok_q) begin
          bal_nxt = diff_q;
          ack_nxt = 1'b1;
        end else begin
          nak_nxt = 1'b1;
        end
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!bus.charge_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bal_q    <= 12'h000;
      price_q  <= 12'h000;
      diff_q   <= 12'h000;
      ok_q     <= 1'b0;
      pend_q   <= 3'b000;
      refund_q <= 1'b0;
      ack_q    <= 1'b0;
      nak_q    <= 1'b0;
      rp_q     <= 1'b0;
    end else begin
      bal_q    <= bal_nxt;
      price_q  <= price_nxt;
      diff_q   <= diff_nxt;
      ok_q     <= ok_nxt;
      pend_q   <= pend_nxt;
      refund_q <= refund_nxt;
      ack_q    <= ack_nxt;
      nak_q    <= nak_nxt;
      rp_q     <= rp_nxt;
    end
  end

  assign bus.bal          = bal_q;
  assign bus.charge_ack   = ack_q;
  assign bus.charge_nak   = nak_q;
  assign bus.refund_pulse = rp_q;

endmodule

// File: tb/tb_balance_ctrl.sv
// tb/tb_balance_ctrl.sv - directed self-checking bench for balance_ctrl
module tb_balance_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] coin;
  logic       refund;

  balance_ctrl_if bus();

  balance_ctrl #(.DB_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .coin   (coin),
    .refund (refund),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event counters sampled at the active edge (pre-update values).
  int          ack_cnt = 0;
  int          nak_cnt = 0;
  int          rp_cnt  = 0;
  int          upd_cnt = 0;
  int          viol    = 0;
  logic        prev_resp = 1'b0;
  logic [11:0] last_bal  = 12'h000;

  always @(posedge clk) begin
    if (bus.charge_ack)   ack_cnt++;
    if (bus.charge_nak)   nak_cnt++;
    if (bus.refund_pulse) rp_cnt++;
    if ((bus.charge_ack && bus.charge_nak) ||
        ((bus.charge_ack || bus.charge_nak) && prev_resp)) viol++;
    prev_resp = bus.charge_ack || bus.charge_nak;
    if (bus.bal !== last_bal) upd_cnt++;
    last_bal = bus.bal;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] c, input logic r, input int hold);
    coin   = c;
    refund = r;
    tick(hold);
    coin   = 3'b000;
    refund = 1'b0;
    tick(12);
  endtask

  // Raise the request and stop on the cycle where the response is visible.
  task automatic charge_start(input logic [11:0] p);
    bus.price      = p;
    bus.charge_req = 1'b1;
    tick(3);
  endtask

  task automatic charge_end(input int hold);
    tick(hold);
    bus.charge_req = 1'b0;
    tick(3);
  endtask

  int n0;
  int a0;
  int k0;
  int r0;

  initial begin
    rst            = 1'b0;
    coin           = 3'b000;
    refund         = 1'b0;
    bus.charge_req = 1'b0;
    bus.price      = 12'h000;
    tick(3);
    check("rst_bal", 32'(bus.bal), 32'h000);
    check("rst_ack", 32'(bus.charge_ack), 0);
    check("rst_nak", 32'(bus.charge_nak), 0);
    check("rst_rp",  32'(bus.refund_pulse), 0);
    rst = 1'b1;
    tick(2);

    // Coin 10 with exact latency: pulse after DB+2 edges, bal one edge later.
    n0   = upd_cnt;
    coin = 3'b100;
    tick(6);
    check("coin_lat_early", 32'(bus.bal), 32'h000);
    tick(1);
    check("coin10", 32'(bus.bal), 32'h010);
    tick(13);
    coin = 3'b000;
    tick(12);
    check("coin10_once", 32'(upd_cnt - n0), 1);

    n0 = upd_cnt;
    press(3'b010, 1'b0, 20);
    check("coin5", 32'(bus.bal), 32'h015);
    check("coin5_once", 32'(upd_cnt - n0), 1);
    n0 = upd_cnt;
    press(3'b001, 1'b0, 20);
    check("coin1", 32'(bus.bal), 32'h016);
    check("coin1_once", 32'(upd_cnt - n0), 1);

    // Charge 12 from 16: response after N+2.
    a0             = ack_cnt;
    bus.price      = 12'h012;
    bus.charge_req = 1'b1;
    tick(2);
    check("chg_lat_ack", 32'(bus.charge_ack), 0);
    check("chg_lat_bal", 32'(bus.bal), 32'h016);
    tick(1);
    check("chg_ack", 32'(bus.charge_ack), 1);
    check("chg_bal", 32'(bus.bal), 32'h004);
    tick(1);
    check("chg_ack_1cyc", 32'(bus.charge_ack), 0);
    charge_end(10);
    check("chg_one_resp", 32'(ack_cnt - a0), 1);

    // Insufficient funds, invalid BCD, zero price.
    charge_start(12'h005);
    check("nak_funds", 32'(bus.charge_nak), 1);
    check("nak_funds_ack", 32'(bus.charge_ack), 0);
    check("nak_funds_bal", 32'(bus.bal), 32'h004);
    charge_end(1);
    charge_start(12'h0A0);
    check("nak_bcd", 32'(bus.charge_nak), 1);
    check("nak_bcd_bal", 32'(bus.bal), 32'h004);
    charge_end(1);
    charge_start(12'h000);
    check("ack_zero", 32'(bus.charge_ack), 1);
    check("ack_zero_bal", 32'(bus.bal), 32'h004);
    charge_end(1);

    // 4 + 10 + 5 + 1 = 20, then exact-balance charge with coins arriving together.
    press(3'b111, 1'b0, 10);
    check("bal20", 32'(bus.bal), 32'h020);
    a0             = ack_cnt;
    bus.price      = 12'h020;
    bus.charge_req = 1'b1;
    coin           = 3'b111;
    tick(3);
    check("sim_ack", 32'(bus.charge_ack), 1);
    check("sim_bal0", 32'(bus.bal), 32'h000);
    tick(1);
    bus.charge_req = 1'b0;
    tick(3);
    check("sim_c10", 32'(bus.bal), 32'h010);
    tick(1);
    check("sim_c5", 32'(bus.bal), 32'h015);
    tick(1);
    check("sim_c1", 32'(bus.bal), 32'h016);
    coin = 3'b000;
    tick(12);
    check("sim_one_resp", 32'(ack_cnt - a0), 1);

    // Refund at 37.
    press(3'b100, 1'b0, 10);
    press(3'b100, 1'b0, 10);
    press(3'b001, 1'b0, 10);
    check("bal37", 32'(bus.bal), 32'h037);
    refund = 1'b1;
    tick(6);
    check("ref_early", 32'(bus.bal), 32'h037);
    tick(1);
    check("ref_bal", 32'(bus.bal), 32'h000);
    check("ref_pulse", 32'(bus.refund_pulse), 1);
    tick(1);
    check("ref_pulse_1cyc", 32'(bus.refund_pulse), 0);
    tick(3);
    refund = 1'b0;
    tick(12);

    // Saturation: 62 * 16 + 3 = 995, +10 -> 999, +1 -> 999.
    for (int i = 0; i < 62; i++) press(3'b111, 1'b0, 10);
    for (int i = 0; i < 3; i++)  press(3'b001, 1'b0, 10);
    check("bal995", 32'(bus.bal), 32'h995);
    press(3'b100, 1'b0, 10);
    check("sat10", 32'(bus.bal), 32'h999);
    press(3'b001, 1'b0, 10);
    check("sat1", 32'(bus.bal), 32'h999);

    // Refund pressed while a request is held is deferred until release.
    r0 = rp_cnt;
    charge_start(12'h0A0);
    check("held_nak", 32'(bus.charge_nak), 1);
    refund = 1'b1;
    tick(10);
    refund = 1'b0;
    tick(12);
    check("ref_defer_bal", 32'(bus.bal), 32'h999);
    check("ref_defer_cnt", 32'(rp_cnt - r0), 0);
    bus.charge_req = 1'b0;
    tick(4);
    check("ref_late_bal", 32'(bus.bal), 32'h000);
    check("ref_late_cnt", 32'(rp_cnt - r0), 1);

    // Reset while in CMP.
    press(3'b010, 1'b0, 10);
    check("bal5", 32'(bus.bal), 32'h005);
    a0             = ack_cnt;
    k0             = nak_cnt;
    bus.price      = 12'h001;
    bus.charge_req = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    check("rcmp_bal", 32'(bus.bal), 32'h000);
    check("rcmp_ack", 32'(bus.charge_ack), 0);
    check("rcmp_nak", 32'(bus.charge_nak), 0);
    check("rcmp_rp",  32'(bus.refund_pulse), 0);
    bus.charge_req = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(5);
    check("rcmp_no_ack", 32'(ack_cnt - a0), 0);
    check("rcmp_no_nak", 32'(nak_cnt - k0), 0);
    check("rcmp_bal_after", 32'(bus.bal), 32'h000);

    check("resp_exclusive", 32'(viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
